key_sched192_seq: RTL and testbench
===================================

KEY_SCHED192_SEQ -- requirements
Module: key_sched192_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port start, input, 1 bit: single-cycle request to expand key.
REQ-004 The block SHALL have the port key, input, 192 bits: cipher key, big-endian, with key[191:160] = w[0].
REQ-005 The block SHALL have the port busy, output, 1 bit: expansion in progress.
REQ-006 The block SHALL have the port done, output, 1 bit: level; the full schedule is valid.
REQ-007 The block SHALL have the port rk_idx, input, 4 bits: round-key read index, 0..12.
REQ-008 The block SHALL have the port rk, output, 128 bits: round key rk_idx, combinational read, with rk[127:96] = w[4*rk_idx].
REQ-009 The block SHALL have no parameters: Nk=6, Nr=12 and 52 words are fixed.

Function
REQ-010 The block SHALL implement a state machine with states IDLE, EXPAND and DONE, entered in that order.
REQ-011 In IDLE or DONE, start=1 SHALL be accepted at the clock edge: w[0..5] loaded from key, w[6..51] cleared to 0, i=6, rcon=8'h01, done=0, busy=1, next state EXPAND.
REQ-012 In EXPAND, each cycle SHALL write exactly one word: w[i] = w[i-6] ^ t.
REQ-013 The term t SHALL be SubWord(RotWord(w[i-1])) ^ {rcon,24'h0} when i mod 6 == 0, and w[i-1] otherwise.
REQ-014 RotWord SHALL be a 1-byte left rotate; SubWord SHALL apply the FIPS-197 forward S-box to each of the 4 bytes.
REQ-015 rcon SHALL update to xtime(rcon) after each word with i mod 6 == 0; it takes values 01,02,04,...,80, and xtime reduction by 8'h1b is never reached.
REQ-016 When w[51] is written, the same edge SHALL set state DONE, busy=0 and done=1.
REQ-017 Latency SHALL be exactly 46 clock edges from the start-accept edge to done=1.
REQ-018 start asserted while in EXPAND SHALL be ignored: no restart, no key re-latch.
REQ-019 start in DONE SHALL restart per REQ-011 and drop done on the accept edge.
REQ-020 key SHALL be sampled only on the accept edge; changes afterwards have no effect.
REQ-021 rk for rk_idx 0..12 SHALL be {w[4n],w[4n+1],w[4n+2],w[4n+3]}; rk SHALL be 128'h0 for rk_idx 13..15.
REQ-022 rk SHALL be readable at any time; during EXPAND, words not yet written read as 0.
REQ-023 The w index counter SHALL be 6 bits and SHALL never exceed 51.
REQ-024 Storage SHALL be 52 x 32-bit registers; the S-box SHALL be a combinational table shared by a single SubWord path.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state IDLE, busy=0, done=0, i=0, rcon=8'h01 and all w to 0, so rk=0.
REQ-026 Reset asserted mid-EXPAND SHALL abort the expansion with no partial done; after release, a new start is required.
REQ-027 start sampled in the same cycle as reset release SHALL be honoured only if rst_n is high at that edge.

Verification
REQ-028 The bench SHALL cover: key 000102030405060708090a0b0c0d0e0f1011121314151617, start -> done after 46 edges; rk_idx 0 = 000102030405060708090a0b0c0d0e0f, rk_idx 1 = 10111213141516175846f2f95c43f4fe, rk_idx 12 = a4970a331a78dc09c418c271e3a41d5d.
REQ-029 The bench SHALL cover: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w[6] = fe0c91f7; rk_idx 12 = e98ba06f448c773c8ecc720401002202.
REQ-030 The bench SHALL cover: start pulsed with a different key at cycle 20 of EXPAND -> ignored; results match the first key; done still at edge 46.
REQ-031 The bench SHALL cover: rst_n low at cycle 30 of EXPAND -> busy=0, done=0, rk=0 immediately, without waiting for a clock edge; a new start then yields the correct schedule.
REQ-032 The bench SHALL cover: rk_idx = 13, 14, 15 in DONE -> rk = 0; back-to-back start in DONE -> done drops on the accept edge and rises again 46 edges later.
REQ-033 The bench SHALL cover: rk_idx=12 read every cycle during EXPAND -> zero until w[48..51] are written, with no X at any time after reset.

Source files
------------

// File: rtl/key_sched192_seq.sv
// AES-192 key expansion: one schedule word per clock into a 52-word register file.
// Round keys are read back combinationally by index once done is high.
module key_sched192_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [191:0] key,
  input  logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done,
  output logic [127:0] rk
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = 2040 - 8 * int'(b);
    return SBOX_FLAT[idx +: 8];
  endfunction

  state_t      state, state_nxt;
  logic [31:0] w [52];
  logic [5:0]  i;
  logic [7:0]  rcon;

  logic        accept;
  logic        key_step;
  logic [31:0] w_prev, w_back, rot, sub, t_word, new_word;
  logic [5:0]  rk_base;

  assign accept   = start && (state != EXPAND);
  assign key_step = (state == EXPAND) && ((i % 6'd6) == 6'd0);

  // Single shared SubWord path; operands are meaningful only while expanding (i >= 6).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_prev = 32'h0;
    w_back = 32'h0;
    if (state == EXPAND) begin
      w_prev = w[i - 6'd1];
      w_back = w[i - 6'd6];
    end
    rot      = {w_prev[23:0], w_prev[31:24]};
    sub      = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t_word   = key_step ? (sub ^ {rcon, 24'h0}) : w_prev;
    new_word = w_back ^ t_word;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EXPAND;
      EXPAND:  if (i == 6'd51) state_nxt = DONE;
      DONE:    if (start) state_nxt = EXPAND;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the word store is reset so a reset (even mid-expansion) reads back as all-zero keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i    <= 6'd0;
      rcon <= 8'h01;
      for (int k = 0; k < 52; k++) w[k] <= 32'h0;
    end else if (accept) begin
      i    <= 6'd6;
      rcon <= 8'h01;
      for (int k = 0; k < 52; k++) w[k] <= (k < 6) ? key[191 - 32*k -: 32] : 32'h0;
    end else if (state == EXPAND) begin
      w[i] <= new_word;
      if (i != 6'd51) i <= i + 6'd1;
      if (key_step)   rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end
  end

  assign busy = (state == EXPAND);
  assign done = (state == DONE);

  assign rk_base = {rk_idx, 2'b00};

  always_comb begin
    rk = 128'h0;
    if (rk_idx <= 4'd12)
      rk = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
  end

endmodule

// File: tb/tb_key_sched192_seq.sv
// Directed bench for key_sched192_seq using known AES-192 schedule vectors.
module tb_key_sched192_seq;

  localparam logic [191:0] K1      = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] K1_RK0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1_RK1  = 128'h10111213141516175846f2f95c43f4fe;
  localparam logic [127:0] K1_RK12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
  localparam logic [191:0] K2      = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [31:0]  K2_W6   = 32'hfe0c91f7;
  localparam logic [127:0] K2_RK12 = 128'he98ba06f448c773c8ecc720401002202;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [191:0] key = '0;
  logic [3:0]   rk_idx = 4'd0;
  logic         busy, done;
  logic [127:0] rk;

  int n_cmp = 0;
  int n_bad = 0;

  key_sched192_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .key    (key),
    .rk_idx (rk_idx),
    .busy   (busy),
    .done   (done),
    .rk     (rk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [191:0] k);
    @(negedge clk);
    key   = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the accept edge until done; -1 if the budget runs out.
  task automatic wait_done(output int edges);
    bit seen;
    seen  = 1'b0;
    edges = -1;
    for (int n = 1; n <= 100 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        edges = n;
        seen  = 1'b1;
      end
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output logic [127:0] val);
    rk_idx = idx;
    #1;
    val = rk;
  endtask

  initial begin
    int           edges;
    logic [127:0] v;
    logic [127:0] e;

    // Reset state
    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rk0", rk, 0);

    // start held across an edge while reset is low must be ignored
    key   = K1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("start_in_reset", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_at_release", busy, 1);
    wait_done(edges);
    check("k1_latency", edges, 46);
    read_rk(4'd0, v);  check("k1_rk0", v, K1_RK0);
    read_rk(4'd1, v);  check("k1_rk1", v, K1_RK1);
    read_rk(4'd12, v); check("k1_rk12", v, K1_RK12);

    // Second vector
    accept(K2);
    check("k2_busy", busy, 1);
    wait_done(edges);
    check("k2_latency", edges, 46);
    read_rk(4'd1, v);  check("k2_w6", v[63:32], K2_W6);
    read_rk(4'd12, v); check("k2_rk12", v, K2_RK12);

    // start with another key during EXPAND is ignored
    accept(K1);
    edges = -1;
    for (int n = 1; n <= 100 && edges < 0; n++) begin
      if (n == 21) begin
        key   = K2;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) edges = n;
    end
    check("ign_latency", edges, 46);
    read_rk(4'd0, v);  check("ign_rk0", v, K1_RK0);
    read_rk(4'd12, v); check("ign_rk12", v, K1_RK12);

    // Asynchronous reset mid-expansion
    accept(K2);
    repeat (30) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_rk12", rk, 0);
    read_rk(4'd0, v);  check("arst_rk0", v, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("arst_stays_idle", {busy, done}, 0);
    accept(K1);
    wait_done(edges);
    check("arst_latency", edges, 46);
    read_rk(4'd12, v); check("arst_rk12_new", v, K1_RK12);

    // Out-of-range indices read zero; back-to-back restart from DONE
    for (int k = 13; k <= 15; k++) begin
      read_rk(4'(k), v);
      check($sformatf("rk_idx_%0d", k), v, 0);
    end
    accept(K2);
    check("b2b_done_drop", done, 0);
    check("b2b_busy", busy, 1);
    wait_done(edges);
    check("b2b_latency", edges, 46);
    read_rk(4'd12, v); check("b2b_rk12", v, K2_RK12);

    // rk_idx 12 watched every cycle of an expansion
    rk_idx = 4'd12;
    accept(K1);
    check("watch_rk12_accept", rk, 0);
    for (int n = 1; n <= 46; n++) begin
      @(posedge clk);
      #1;
      e = '0;
      for (int j = 0; j < 4; j++)
        if (n >= 43 + j) e[127 - 32*j -: 32] = K1_RK12[127 - 32*j -: 32];
      check($sformatf("watch_rk12_c%0d", n), rk, e);
    end
    check("watch_done", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
